// File: rtl/core_bus_arb.sv
// Two-master shared-memory arbiter: m0 (data) has priority and m1 (fetch) gets a fairness slot.
// Optional slave timeout abort is enabled with `define ARB_TIMEOUT_EN.
module core_bus_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_ack_o,
  input  logic          m1_req_i,
  input  logic [AW-1:0] m1_addr_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_ack_o,
  output logic          s_req_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_ack_i,
  output logic          hold_flag_o,
  output logic          err_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] FMAX = 4'(FAIR_MAX);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    fair_q, fair_d;
  logic          busy;
  logic          pick_m1;
  logic          tmo;
  logic          done;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  assign tmo = busy & (timer_q == 8'(TIMEOUT)) & ~s_ack_i;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign tmo = 1'b0;
`endif

  assign busy    = (state_q == BUSY);
  assign pick_m1 = m1_req_i & (~m0_req_i | (fair_q == FMAX));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fair_d  = fair_q;
`ifdef ARB_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req_i | m1_req_i) begin
          state_d = BUSY;
          gnt_d   = pick_m1;
`ifdef ARB_TIMEOUT_EN
          timer_d = 8'd1;
`endif
          if (pick_m1) begin
            addr_d  = m1_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            fair_d  = 4'd0;
          end else begin
            addr_d  = m0_addr_i;
            we_d    = m0_we_i;
            wdata_d = m0_wdata_i;
            if (!m1_req_i)
              fair_d = 4'd0;
            else if (fair_q < FMAX)
              fair_d = fair_q + 4'd1;
          end
        end
      end
      BUSY: begin
        if (s_ack_i | tmo) begin
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          timer_d = timer_q + 8'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fair_q  <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      timer_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fair_q  <= fair_d;
`ifdef ARB_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  // Reset wins over a same-cycle slave ack so an abandoned transfer never acks.
  assign done       = busy & (s_ack_i | tmo) & ~rst;
  assign m0_ack_o   = done & ~gnt_q;
  assign m1_ack_o   = done & gnt_q;
  assign m0_rdata_o = (m0_ack_o & s_ack_i) ? s_rdata_i : '0;
  assign m1_rdata_o = (m1_ack_o & s_ack_i) ? s_rdata_i : '0;
  assign err_o      = tmo & ~rst;

  assign s_req_o   = busy;
  assign s_we_o    = busy & we_q;
  assign s_addr_o  = busy ? addr_q : '0;
  assign s_wdata_o = busy ? wdata_q : '0;

  assign hold_flag_o = (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o);

endmodule

// File: tb/tb_core_bus_arb.sv
// Bench for core_bus_arb: vector table, fairness run, reset abort.
// Expected acks go to a scoreboard queue and are checked as acks appear.
module tb_core_bus_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_we_i, m1_req_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m1_ack_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;
  logic        hold_flag_o, err_o;

  core_bus_arb #(
    .AW(32), .DW(32), .FAIR_MAX(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
    .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    bit          drop;
  } vec_t;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(output bit seen);
    exp_t e;
    seen = 1'b0;
    chk("dual_ack", {31'd0, m0_ack_o & m1_ack_o}, 32'd0);
    if (m0_ack_o | m1_ack_o) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_master", {31'd0, m1_ack_o}, {31'd0, e.m});
        chk("ack_rdata", e.m ? m1_rdata_o : m0_rdata_o, e.rdata);
        chk("other_rdata", e.m ? m0_rdata_o : m1_rdata_o, 32'd0);
        chk("ack_err", {31'd0, err_o}, {31'd0, e.err});
      end
    end else begin
      chk("idle_err", {31'd0, err_o}, 32'd0);
      chk("idle_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   ackc;
    int   k;
    bit   seen;
    bit   tmo_hit;
    logic reqnow;
`ifdef ARB_TIMEOUT_EN
    tmo_hit = (v.dly == 0) || (v.dly > TMO);
`else
    tmo_hit = 1'b0;
`endif
    ackc    = tmo_hit ? TMO : v.dly;
    e.m     = v.m;
    e.err   = tmo_hit;
    e.rdata = tmo_hit ? 32'd0 : v.rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    m0_req_i   = ~v.m;
    m1_req_i   = v.m;
    m0_we_i    = v.we;
    m0_addr_i  = v.m ? ~v.addr : v.addr;
    m1_addr_i  = v.m ? v.addr : ~v.addr;
    m0_wdata_i = v.wdata;
    s_ack_i    = 1'b0;
    s_rdata_i  = ~v.rdata;
    @(negedge clk);
    chk("idle_sreq", {31'd0, s_req_o}, 32'd0);
    chk("idle_hold", {31'd0, hold_flag_o}, 32'd1);
    sample(seen);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      k++;
      @(posedge clk); #1;
      if (v.drop && k == 2) begin
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
      end
      s_ack_i   = (k == v.dly);
      s_rdata_i = s_ack_i ? v.rdata : ~v.rdata;
      @(negedge clk);
      reqnow = v.m ? m1_req_i : m0_req_i;
      chk("busy_sreq", {31'd0, s_req_o}, 32'd1);
      chk("busy_addr", s_addr_o, v.addr);
      chk("busy_we", {31'd0, s_we_o}, {31'd0, v.we & ~v.m});
      chk("busy_wdata", s_wdata_o, v.m ? 32'd0 : v.wdata);
      chk("busy_hold", {31'd0, hold_flag_o},
          {31'd0, reqnow & (k != ackc)});
      sample(seen);
    end
    chk("ack_cycle", 32'(k), 32'(ackc));
    @(posedge clk); #1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    s_ack_i  = 1'b0;
  endtask

  initial begin
    bit   seen;
    int   cnt;
    exp_t e;
    bit   order [10];
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    vecs[0] = '{0, 0, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 3, 0};
    vecs[1] = '{0, 1, 32'h2000_0004, 32'h1234_5678, 32'h0BAD_F00D, 5, 0};
    vecs[2] = '{1, 1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0013, 1, 0};
    vecs[3] = '{0, 0, 32'h1000_0008, 32'h0, 32'hCAFE_0001, 1, 0};
    vecs[4] = '{1, 0, 32'h0000_0044, 32'h0, 32'h0000_0033, 4, 1};
`ifdef ARB_TIMEOUT_EN
    vecs[5] = '{1, 0, 32'h0000_0080, 32'h0, 32'h1111_1111, 0, 0};
    vecs[6] = '{0, 0, 32'h1000_0010, 32'h0, 32'h2222_2222, TMO, 0};
`else
    vecs[5] = '{1, 0, 32'h0000_0080, 32'h0, 32'h1111_1111, 101, 0};
    vecs[6] = '{0, 0, 32'h1000_0010, 32'h0, 32'h2222_2222, 2, 0};
`endif

    rst = 1'b1;
    m0_req_i = 0; m0_we_i = 0; m1_req_i = 0; s_ack_i = 0;
    m0_addr_i = 0; m0_wdata_i = 0; m1_addr_i = 0; s_rdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sreq", {31'd0, s_req_o}, 32'd0);
    chk("rst_swe", {31'd0, s_we_o}, 32'd0);
    chk("rst_addr", s_addr_o, 32'd0);
    chk("rst_wdata", s_wdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    chk("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int i = 0; i < 10; i++) begin
      e.m = order[i];
      e.rdata = 32'h5A5A_0000;
      e.err = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    m0_req_i = 1; m1_req_i = 1; m0_we_i = 0;
    m0_addr_i = 32'h1000_0100; m1_addr_i = 32'h0000_0200;
    s_ack_i = 1; s_rdata_i = 32'h5A5A_0000;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 10; c++) begin
      @(negedge clk);
      sample(seen);
      if (seen) cnt++;
      if (cnt < 10) @(posedge clk);
    end
    chk("fair_count", 32'(cnt), 32'd10);
    @(posedge clk); #1;
    m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;

    @(posedge clk); #1;
    m0_req_i = 1; m0_addr_i = 32'h3000_0000;
    @(negedge clk); sample(seen);
    @(posedge clk); #1;
    @(negedge clk); sample(seen);
    chk("pre_rst_sreq", {31'd0, s_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); sample(seen);
    chk("rst_busy_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req_i = 0;
    @(negedge clk); sample(seen);
    chk("post_rst_sreq", {31'd0, s_req_o}, 32'd0);
    run_vec('{1, 0, 32'h0000_0100, 32'h0, 32'h0000_0093, 2, 0});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
